// File: rtl/nios_led_oci_trace_pkg.sv
// Shared types and constants for the nios_led OCI trace capture slice.
// OCI_TRACE_TIMESTAMP_EN adds a timestamp field to each entry's MSBs.
package nios_led_oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_ENDED   = 2'd3
  } trace_state_e;

  localparam int DCT_W_DEF = 30;
  localparam int CNT_W_DEF = 4;
  localparam int TS_W_DEF  = 16;

`ifdef OCI_TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Entry field offsets for the default widths: {[ts,] count, buffer}
  localparam int ENT_BUF_LSB = 0;
  localparam int ENT_CNT_LSB = DCT_W_DEF;
  localparam int ENT_TS_LSB  = DCT_W_DEF + CNT_W_DEF;

  function automatic int entry_width(input int dct_w, input int cnt_w, input int ts_w);
    return dct_w + cnt_w + (TS_EN ? ts_w : 0);
  endfunction

endpackage

// File: rtl/nios_led_oci_trace_fifo.sv
// DEPTH x W synchronous FIFO with first-word-fall-through read port.
// A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module nios_led_oci_trace_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == LW'(DEPTH));
  assign level = r_cnt;
  assign rdata = r_mem[r_rd];

  assign w_rd = pop && !empty;
  assign w_wr = push && (!full || w_rd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= wdata;
  end

endmodule

// File: rtl/nios_led_oci_trace_capture.sv
// OCI debug-trace capture: filtered push into a FWFT FIFO, overflow count, end-of-test drain.
// Define OCI_TRACE_TIMESTAMP_EN to prepend a free-running timestamp to every entry.
module nios_led_oci_trace_capture
  import nios_led_oci_trace_pkg::*;
#(
  parameter int DCT_W = DCT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = 16,
  parameter int OVF_W = 8,
  parameter int TS_W  = TS_W_DEF,
  localparam int LVL_W   = $clog2(DEPTH) + 1,
  localparam int ENTRY_W = entry_width(DCT_W, CNT_W, TS_W)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               trace_en,
  input  logic               dct_valid,
  input  logic [DCT_W-1:0]   dct_buffer,
  input  logic [CNT_W-1:0]   dct_count,
  input  logic               test_ending,
  input  logic               clear,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [LVL_W-1:0]   fill_level,
  output logic [OVF_W-1:0]   overflow_cnt,
  output logic               test_has_ended,
  output logic               busy
);

  trace_state_e       r_state;
  logic               r_ended;
  logic               r_busy;
  logic [OVF_W-1:0]   r_ovf;
  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_rdata;
  logic [LVL_W-1:0]   w_level;
  logic               w_full;
  logic               w_empty;
  logic               w_push_req;
  logic               w_pop;
  logic               w_drop;

`ifdef OCI_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_ts <= '0;
    else if (clear) r_ts <= '0;
    else            r_ts <= r_ts + 1'b1;
  end

  assign w_entry = {r_ts, dct_count, dct_buffer};
`else
  assign w_entry = {dct_count, dct_buffer};
`endif

  assign w_push_req = (r_state == ST_CAPTURE) && dct_valid && (dct_count != '0) && !clear;
  assign w_pop      = !w_empty && rd_ready && !clear;
  assign w_drop     = w_push_req && w_full && !w_pop;

  nios_led_oci_trace_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (w_push_req),
    .pop     (w_pop),
    .wdata   (w_entry),
    .rdata   (w_rdata),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ended <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= '0;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_ended <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= '0;
    end else begin
      if (w_drop && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (test_ending) begin
            r_state <= ST_DRAIN;
            r_busy  <= 1'b1;
          end else if (trace_en) begin
            r_state <= ST_CAPTURE;
            r_busy  <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (test_ending) begin
            r_state <= ST_DRAIN;
          end else if (!trace_en) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        // Registered level: ENDED follows the cycle in which fill_level shows 0
        ST_DRAIN: begin
          if (w_level == '0) begin
            r_state <= ST_ENDED;
            r_ended <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_ENDED;
      endcase
    end
  end

  assign rd_valid       = !w_empty;
  assign rd_data        = w_empty ? '0 : w_rdata;
  assign fill_level     = w_level;
  assign overflow_cnt   = r_ovf;
  assign test_has_ended = r_ended;
  assign busy           = r_busy;

endmodule

// File: doc/nios_led_oci_trace_capture.md
Name: nios_led_oci_trace_capture

Overview:
- Parametrised next-generation OCI debug-trace capture block for the nios_led system.
- Accepts compressed debug-trace words (dct_buffer) with their valid-slot count (dct_count) from the OCI and buffers them in an internal FIFO.
- Exposes the FIFO through a valid/ready readout port for JTAG-side or bench draining.
- Sequences end-of-test: on test_ending it drains the FIFO, then asserts test_has_ended.

Parameters:
- DCT_W, 30, width of dct_buffer.
- CNT_W, 4, width of dct_count.
- DEPTH, 16, FIFO entries; must be a power of two, ≥2.
- OVF_W, 8, width of the saturating overflow counter.
- TS_W, 16, timestamp width; used only when the optional feature is enabled.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- trace_en  in  1  capture enable.
- dct_valid  in  1  trace word strobe.
- dct_buffer  in  DCT_W  compressed trace word.
- dct_count  in  CNT_W  number of valid slots in dct_buffer.
- test_ending  in  1  end-of-test request (level or pulse).
- clear  in  1  synchronous clear of FIFO, counters and state.
- rd_ready  in  1  readout sink ready.
- rd_valid  out  1  rd_data holds a valid entry.
- rd_data  out  ENTRY_W  entry = {[ts,] dct_count, dct_buffer}; ENTRY_W = CNT_W+DCT_W (+TS_W).
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow_cnt  out  OVF_W  dropped-word count, saturating.
- test_has_ended  out  1  drain complete.
- busy  out  1  state is CAPTURE or DRAIN.

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous assert, active-low.
- Reset values: all outputs 0, state IDLE, FIFO empty.
- States: IDLE, CAPTURE, DRAIN, ENDED (2-bit encoding).
- IDLE -> CAPTURE when trace_en=1.
- CAPTURE -> IDLE when trace_en=0; FIFO contents are retained.
- CAPTURE -> DRAIN when test_ending=1. test_ending has priority over trace_en=0 in the same cycle.
- DRAIN -> ENDED on the cycle after fill_level reaches 0.
- test_has_ended is registered and asserts in ENDED. It holds until clear=1 or reset.
- IDLE -> DRAIN on test_ending as well, so an end request without prior capture still completes.
- Push rule: only in CAPTURE, when dct_valid=1 and dct_count≠0.
  - dct_count=0 words are discarded silently and are not counted as overflow.
- Pop rule: a pop occurs when rd_valid=1 and rd_ready=1.
  - Readout is first-word-fall-through: rd_valid=1 whenever fill_level>0.
  - rd_data must be stable while rd_valid=1 and rd_ready=0.
- Full FIFO: a push is dropped and overflow_cnt increments, saturating at 2^OVF_W-1.
  - Exception: a simultaneous pop in the same cycle frees a slot, so the push is accepted with no drop.
- Empty FIFO: rd_ready is ignored.
- Push and pop in the same cycle on a non-full FIFO: fill_level is unchanged.
- fill_level is registered and updates the cycle after push/pop. Pointers wrap modulo DEPTH.
- Latency: an accepted word appears on rd_data one cycle after the push when the FIFO was empty.
- clear (any state): empties the FIFO, zeroes overflow_cnt, deasserts test_has_ended, returns to IDLE next cycle.
  - clear has priority over all other events.
- Inputs other than clear, rd_ready and trace_en are ignored in ENDED.
- Reset mid-drain: immediate return to reset values; buffered entries are lost.

Optional Feature:
- Macro: OCI_TRACE_TIMESTAMP_EN.
- Defined:
  - A TS_W-bit free-running counter runs from reset, wraps at 2^TS_W, and is zeroed by clear.
  - Its value at the push cycle is prepended as the MSBs of each entry; ENTRY_W includes TS_W.
- Undefined: no counter exists, ENTRY_W = CNT_W+DCT_W, and all other behaviour is identical.

Decomposition:
- Shared package nios_led_oci_trace_pkg holds:
  - the state enum (IDLE, CAPTURE, DRAIN, ENDED);
  - default width constants (DCT_W=30, CNT_W=4);
  - the entry field offset localparams.
- One sub-module: nios_led_oci_trace_fifo.
  - Parametrised DEPTH × width synchronous FIFO with FWFT output.
  - Provides full, empty and level outputs.
  - Top level keeps the FSM, the push filter, the overflow counter and the timestamp.

Test Plan:
- Basic capture: trace_en=1, push 3 words (0x0000_0001/cnt 1, 0x3FFF_FFFF/cnt 15, 0x1555_5555/cnt 4) with rd_ready=0 -> fill_level=3; then rd_ready=1 pops all three in order and rd_valid drops.
- Zero count: dct_valid=1 with dct_count=0 for 5 cycles -> fill_level stays 0, overflow_cnt stays 0.
- Overflow: push 20 words with DEPTH=16 and rd_ready=0 -> fill_level=16, overflow_cnt=4.
  - Then push while full with rd_ready=1 in the same cycle -> accepted, overflow_cnt stays 4.
- End-of-test drain: 5 entries buffered, pulse test_ending, rd_ready=1 -> busy through the drain, test_has_ended=1 exactly one cycle after fill_level hits 0.
  - Subsequent dct_valid pushes are ignored.
- Clear and reset: clear in ENDED -> IDLE, fill_level=0, overflow_cnt=0, test_has_ended=0.
  - Assert reset_n=0 mid-DRAIN between clock edges -> outputs zero immediately, without waiting for a clock edge.
- Timestamp, with OCI_TRACE_TIMESTAMP_EN: pushes 10 cycles apart -> entry timestamp fields differ by 10.
  - Counter wrap from 0xFFFF to 0x0000 is checked.
